breath_ctrl: RTL and testbench

//   Control and timing front-end for the breathing LED logic, on clk_pwm.
//   - Synchronises and debounces the mode and pause push-buttons.
//   - Generates the breathing step tick (breath_tick) from PWM frame boundaries.
//   - Commits mode changes only on a PWM frame boundary, so the downstream
//     LED logic never switches pattern mid-frame.

---
 rtl/breath_ctrl.sv | 102 ++++++++++
 tb/tb_breath_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/breath_ctrl.sv
// breath_ctrl: button sync/debounce, PWM frame and breath tick timing, frame-aligned mode commit.
// Optional automatic mode cycling is built only when BREATH_AUTO_CYCLE_EN is defined.
module breath_ctrl #(
  parameter int FRAME_LEN   = 256,
  parameter int TICK_FRAMES = 1,
  parameter int DEB_CYCLES  = 20000
`ifdef BREATH_AUTO_CYCLE_EN
  , parameter int AUTO_TICKS = 2040
`endif
) (
  input  logic clk_pwm,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_pause,
  output logic mode,
  output logic paused,
  output logic frame_start,
  output logic breath_tick
);
  localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam int TW = TICK_FRAMES > 1 ? $clog2(TICK_FRAMES) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [1:0] s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, dly_q, dly_d, rise;
  logic [DW-1:0] dc_q [2];
  logic [DW-1:0] dc_d [2];
  logic [FW-1:0] fc_q, fc_d;
  logic [TW-1:0] td_q, td_d;
  logic fs_q, fs_d, bt_q, bt_d, paused_q, paused_d, pend_q, pend_d, mode_q, mode_d;
  logic last, adv, twrap, aset;
  // Bit 0 is the mode button, bit 1 the pause button; debounce counts while sync differs from the accepted level
  always_comb begin
    s1_d = {btn_pause, btn_mode};
    s2_d = s1_q;
    dly_d = deb_q;
    rise = deb_q & ~dly_q;
    for (int i = 0; i < 2; i++) begin
      dc_d[i] = (s2_q[i] == deb_q[i] || dc_q[i] == DW'(DEB_CYCLES - 1)) ? '0 : dc_q[i] + DW'(1);
      deb_d[i] = (s2_q[i] != deb_q[i] && dc_q[i] == DW'(DEB_CYCLES - 1)) ? s2_q[i] : deb_q[i];
    end
  end
  // Frame counter, breath divider, pause toggle and mode commit on the last cycle of a frame
  always_comb begin
    last = fc_q == FW'(FRAME_LEN - 1);
    fc_d = last ? '0 : fc_q + FW'(1);
    fs_d = last;
    adv = last & ~paused_q;
    twrap = td_q == TW'(TICK_FRAMES - 1);
    td_d = adv ? (twrap ? '0 : td_q + TW'(1)) : td_q;
    bt_d = adv & twrap;
    paused_d = paused_q ^ rise[1];
    pend_d = rise[0] | aset | (pend_q & ~last);
    mode_d = mode_q ^ (last & pend_q);
  end
  // State registers
  always_ff @(posedge clk_pwm or posedge rst)
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      deb_q <= '0;
      dly_q <= '0;
      dc_q <= '{default: '0};
      fc_q <= '0;
      td_q <= '0;
      fs_q <= 1'b0;
      bt_q <= 1'b0;
      paused_q <= 1'b0;
      pend_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      deb_q <= deb_d;
      dly_q <= dly_d;
      dc_q <= dc_d;
      fc_q <= fc_d;
      td_q <= td_d;
      fs_q <= fs_d;
      bt_q <= bt_d;
      paused_q <= paused_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
    end
`ifdef BREATH_AUTO_CYCLE_EN
  localparam int AW = AUTO_TICKS > 1 ? $clog2(AUTO_TICKS) : 1;
  logic [AW-1:0] ac_q, ac_d;
  // Count breath ticks; a manual mode press restarts the count
  always_comb begin
    aset = bt_q & (ac_q == AW'(AUTO_TICKS - 1));
    ac_d = (rise[0] | aset) ? '0 : ac_q + AW'(bt_q);
  end
  // Auto-cycle counter register
  always_ff @(posedge clk_pwm or posedge rst)
    if (rst) ac_q <= '0;
    else ac_q <= ac_d;
`else
  assign aset = 1'b0;
`endif
  assign mode = mode_q;
  assign paused = paused_q;
  assign frame_start = fs_q;
  assign breath_tick = bt_q;
endmodule

// File: tb/tb_breath_ctrl.sv
// tb_breath_ctrl: scenario tasks plus randomized buttons against a behavioural model of breath_ctrl.
module tb_breath_ctrl;
  localparam int F = 8, TF = 2, D = 4, AT = 3;
  logic clk_pwm = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_pause = 1'b0;
  logic mode, paused, frame_start, breath_tick;
  int n_cmp = 0, n_bad = 0;
  breath_ctrl #(
    .FRAME_LEN(F), .TICK_FRAMES(TF), .DEB_CYCLES(D)
`ifdef BREATH_AUTO_CYCLE_EN
    , .AUTO_TICKS(AT)
`endif
  ) u_dut (
    .clk_pwm(clk_pwm), .rst(rst), .btn_mode(btn_mode), .btn_pause(btn_pause),
    .mode(mode), .paused(paused), .frame_start(frame_start), .breath_tick(breath_tick)
  );
  always #5 clk_pwm = ~clk_pwm;
  // Reference model: t = clock edges since reset release; a level is accepted once the
  // synchronised button (raw delayed two edges) has differed for D consecutive edges.
  int t, uf, ts;
  logic [D+1:0] hm, hp;
  logic dm, dmp, dp, dpp, e_mode, e_paused, e_fs, e_bt, e_pend, bnd, m_rise, p_rise, a_set;
  function automatic logic accept(input logic [D+1:0] h, input logic d);
    return d ? (h[D:1] == '0) : (&h[D:1]);
  endfunction
  assign bnd = ((t + 1) % F) == 0;
  assign m_rise = dm & ~dmp;
  assign p_rise = dp & ~dpp;
`ifdef BREATH_AUTO_CYCLE_EN
  assign a_set = e_bt && (ts + 1 == AT);
`else
  assign a_set = 1'b0;
`endif
  // Model state advance on every clock edge
  always @(posedge clk_pwm or posedge rst)
    if (rst) begin
      t <= 0; uf <= 0; ts <= 0; hm <= '0; hp <= '0;
      dm <= 0; dmp <= 0; dp <= 0; dpp <= 0;
      e_mode <= 0; e_paused <= 0; e_fs <= 0; e_bt <= 0; e_pend <= 0;
    end else begin
      t <= t + 1;
      hm <= {hm[D:0], btn_mode};
      hp <= {hp[D:0], btn_pause};
      dm <= dm ^ accept(hm, dm);
      dp <= dp ^ accept(hp, dp);
      dmp <= dm;
      dpp <= dp;
      e_paused <= e_paused ^ p_rise;
      e_fs <= bnd;
      if (bnd && !e_paused) uf <= uf + 1;
      e_bt <= bnd && !e_paused && ((uf + 1) % TF == 0);
      e_pend <= m_rise | a_set | (e_pend & ~bnd);
      e_mode <= e_mode ^ (bnd & e_pend);
      ts <= m_rise ? 0 : (e_bt ? (ts + 1) % AT : ts);
    end
  task automatic apply_reset;
    @(negedge clk_pwm);
    rst = 1'b1; btn_mode = 1'b0; btn_pause = 1'b0;
    repeat (2) @(negedge clk_pwm);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk_pwm);
    n_cmp++;
    if ({mode, paused, frame_start, breath_tick} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_outputs got %b want 0000", {mode, paused, frame_start, breath_tick});
    end
    rst = 1'b0;
  endtask
  task automatic test_frame;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_pwm);
      n_cmp++;
      if ({mode, paused, frame_start, breath_tick} !== {2'b00, c % F == 0, c % (F * TF) == 0}) begin
        n_bad++; $display("FAIL frame_timing c=%0d got %b want %b", c, {mode, paused, frame_start, breath_tick}, {2'b00, c % F == 0, c % (F * TF) == 0});
      end
    end
  endtask
  task automatic test_glitch;
    apply_reset;
    btn_mode = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk_pwm);
      if (c == 3) btn_mode = 1'b0;
      n_cmp++;
      if (mode !== 1'b0 || {mode, paused, frame_start, breath_tick} !== {e_mode, e_paused, e_fs, e_bt}) begin
        n_bad++; $display("FAIL glitch_mode c=%0d got %b want mode 0 model %b", c, {mode, paused, frame_start, breath_tick}, {e_mode, e_paused, e_fs, e_bt});
      end
    end
  endtask
  task automatic test_mode_commit;
    int exp_t, got_t;
    apply_reset;
    repeat (3) @(negedge clk_pwm);
    btn_mode = 1'b1;
    exp_t = ((t + D + 3) / F + 1) * F;
    got_t = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_pwm);
      n_cmp++;
      if ({mode, paused, frame_start, breath_tick} !== {e_mode, e_paused, e_fs, e_bt}) begin
        n_bad++; $display("FAIL mode_model t=%0d got %b want %b", t, {mode, paused, frame_start, breath_tick}, {e_mode, e_paused, e_fs, e_bt});
      end
      if (mode === 1'b1 && got_t < 0) begin
        got_t = t;
        n_cmp++;
        if (frame_start !== 1'b1) begin
          n_bad++; $display("FAIL mode_with_frame_start got fs=%b want 1", frame_start);
        end
      end
    end
    n_cmp++;
    if (got_t != exp_t) begin
      n_bad++; $display("FAIL mode_commit_time got t=%0d want t=%0d", got_t, exp_t);
    end
    btn_mode = 1'b0;
    repeat (20) @(negedge clk_pwm);
    n_cmp++;
    if (mode !== 1'b1) begin
      n_bad++; $display("FAIL mode_release_no_effect got %b want 1", mode);
    end
  endtask
  task automatic test_pause;
    int got, nfs, t1, t2;
    apply_reset;
    repeat (3) @(negedge clk_pwm);
    btn_pause = 1'b1;
    got = -1;
    for (int k = 1; k <= D + 8; k++) begin
      @(negedge clk_pwm);
      if (paused === 1'b1 && got < 0) got = k;
    end
    n_cmp++;
    if (got != D + 3) begin
      n_bad++; $display("FAIL pause_latency got %0d want %0d", got, D + 3);
    end
    nfs = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_pwm);
      nfs += int'(frame_start);
      n_cmp++;
      if (breath_tick !== 1'b0 || paused !== 1'b1 || {mode, paused, frame_start, breath_tick} !== {e_mode, e_paused, e_fs, e_bt}) begin
        n_bad++; $display("FAIL paused_no_tick c=%0d got %b want %b", c, {mode, paused, frame_start, breath_tick}, {e_mode, e_paused, e_fs, e_bt});
      end
    end
    n_cmp++;
    if (nfs != 5) begin
      n_bad++; $display("FAIL paused_frames got %0d want 5", nfs);
    end
    btn_pause = 1'b0;
    repeat (10) @(negedge clk_pwm);
    btn_pause = 1'b1;
    got = -1;
    for (int k = 1; k <= D + 8; k++) begin
      @(negedge clk_pwm);
      if (paused === 1'b0 && got < 0) got = k;
    end
    n_cmp++;
    if (got != D + 3) begin
      n_bad++; $display("FAIL unpause_latency got %0d want %0d", got, D + 3);
    end
    t1 = -1; t2 = -1;
    for (int c = 1; c <= 80 && t2 < 0; c++) begin
      @(negedge clk_pwm);
      n_cmp++;
      if ({mode, paused, frame_start, breath_tick} !== {e_mode, e_paused, e_fs, e_bt}) begin
        n_bad++; $display("FAIL unpause_model t=%0d got %b want %b", t, {mode, paused, frame_start, breath_tick}, {e_mode, e_paused, e_fs, e_bt});
      end
      if (breath_tick === 1'b1) begin
        if (t1 < 0) t1 = t;
        else t2 = t;
      end
    end
    n_cmp++;
    if (t1 < 0 || t2 - t1 != F * TF) begin
      n_bad++; $display("FAIL tick_spacing got %0d want %0d", t2 - t1, F * TF);
    end
    btn_pause = 1'b0;
  endtask
  task automatic test_reset_pending;
    int c;
    apply_reset;
    btn_mode = 1'b1;
    c = 0;
    while (!e_pend && c < 30) begin
      @(negedge clk_pwm);
      c++;
    end
    n_cmp++;
    if (!e_pend) begin
      n_bad++; $display("FAIL pending_setup got 0 want 1 within 30 cycles");
    end
    rst = 1'b1;
    btn_mode = 1'b0;
    @(negedge clk_pwm);
    n_cmp++;
    if ({mode, paused, frame_start, breath_tick} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_mid_op got %b want 0000", {mode, paused, frame_start, breath_tick});
    end
    rst = 1'b0;
    for (int k = 1; k <= 2 * F; k++) begin
      @(negedge clk_pwm);
      n_cmp++;
      if (mode !== 1'b0 || frame_start !== (k % F == 0)) begin
        n_bad++; $display("FAIL reset_discards_pending k=%0d got mode=%b fs=%b want mode=0 fs=%b", k, mode, frame_start, k % F == 0);
      end
    end
  endtask
`ifdef BREATH_AUTO_CYCLE_EN
  task automatic test_auto;
    int nt, togg;
    logic pm;
    apply_reset;
    nt = 0; togg = 0; pm = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_pwm);
      if (breath_tick === 1'b1) nt++;
      if (mode !== pm) begin
        n_cmp++;
        if (nt != AT || frame_start !== 1'b1) begin
          n_bad++; $display("FAIL auto_period got %0d ticks fs=%b want %0d ticks fs=1", nt, frame_start, AT);
        end
        nt = 0; togg++; pm = mode;
      end
    end
    n_cmp++;
    if (togg != 4) begin
      n_bad++; $display("FAIL auto_toggle_count got %0d want 4", togg);
    end
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk_pwm);
      btn_mode = (c >= 20 && c < 27);
      n_cmp++;
      if ({mode, paused, frame_start, breath_tick} !== {e_mode, e_paused, e_fs, e_bt}) begin
        n_bad++; $display("FAIL auto_restart t=%0d got %b want %b", t, {mode, paused, frame_start, breath_tick}, {e_mode, e_paused, e_fs, e_bt});
      end
    end
    btn_mode = 1'b0;
  endtask
`endif
  task automatic test_random;
    int lm, lp;
    apply_reset;
    lm = 0; lp = 0;
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk_pwm);
      n_cmp++;
      if ({mode, paused, frame_start, breath_tick} !== {e_mode, e_paused, e_fs, e_bt}) begin
        n_bad++; $display("FAIL random_model t=%0d got %b want %b", t, {mode, paused, frame_start, breath_tick}, {e_mode, e_paused, e_fs, e_bt});
      end
      if (lm == 0) begin btn_mode = 1'($urandom_range(0, 1)); lm = $urandom_range(1, 12); end
      if (lp == 0) begin btn_pause = 1'($urandom_range(0, 1)); lp = $urandom_range(1, 16); end
      lm--; lp--;
      if (c == 700) rst = 1'b1;
      if (c == 702) rst = 1'b0;
    end
  endtask
  initial begin
    test_reset;
    test_frame;
    test_glitch;
    test_mode_commit;
    test_pause;
    test_reset_pending;
`ifdef BREATH_AUTO_CYCLE_EN
    test_auto;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
